// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port. Zero-latency read port plus a byte-stream boot loader
// that fills the array from a valid/ready source. The core is held in reset until a full image has landed.
//
//  state  | meaning
//  S_LEN0 | waiting for low byte of the word count
//  S_LEN1 | waiting for high byte of the word count
//  S_DATA | assembling little-endian words and writing them to the array
//  S_DONE | image complete, core released, waiting for load_start_i
module inst_rom_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   input  logic        load_start_i,
   output logic        cpu_rst_o,
   output logic        load_done_o,
   output logic        load_err_o,
   output logic [15:0] load_count_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   typedef enum logic [1:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] word_ptr_q, word_ptr_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        accept;
   logic        mem_we;
   logic [31:0] mem_wdata;

   logic [31:0] mem_q [DEPTH];

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_ptr_d = word_ptr_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_wdata  = {in_data_i, shift_q};
      in_ready_o = (state_q != S_DONE);
      accept     = in_valid_i && in_ready_o;

      case (state_q)
         S_LEN0: begin
            if (accept) begin
               len_d[7:0] = in_data_i;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (accept) begin
               len_d[15:8] = in_data_i;
               byte_cnt_d  = 2'd0;
               if ({in_data_i, len_q[7:0]} == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_d = 2'd0;
                  // Words past the end of the array are counted but never written.
                  if ({1'b0, word_ptr_q} < DEPTH_W) begin
                     mem_we = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  word_ptr_d = word_ptr_q + 16'd1;
                  if (word_ptr_d == len_q) begin
                     state_d = S_DONE;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0:    shift_d[7:0]   = in_data_i;
                     2'd1:    shift_d[15:8]  = in_data_i;
                     default: shift_d[23:16] = in_data_i;
                  endcase
               end
            end
         end
         S_DONE: begin
            if (load_start_i) begin
               state_d    = S_LEN0;
               word_ptr_d = 16'd0;
               byte_cnt_d = 2'd0;
               err_d      = 1'b0;
            end
         end
         default: state_d = S_LEN0;
      endcase

      cpu_rst_d = (state_d != S_DONE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LEN0;
         len_q      <= 16'd0;
         word_ptr_q <= 16'd0;
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
         cpu_rst_q  <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_ptr_q <= word_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         cpu_rst_q  <= cpu_rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Array has no reset so an image survives a core or loader reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[word_ptr_q[ADDR_WIDTH-1:0]] <= mem_wdata;
      end
   end

   logic addr_in_range;
   logic unused_addr_lsb;

   assign addr_in_range   = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
   assign unused_addr_lsb = ^rom_addr_i[1:0];
   assign rom_data_o      = (rom_ce_i && addr_in_range) ? mem_q[rom_addr_i[ADDR_WIDTH+1:2]] : 32'd0;

   assign cpu_rst_o    = cpu_rst_q;
   assign load_done_o  = done_q;
   assign load_err_o   = err_q;
   assign load_count_o = word_ptr_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a default-size instance and a 4-word instance share stimulus;
// expected values are hand-computed from the frame contents.
module tb_inst_rom_loader;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        load_start;

   logic [31:0] rom_data;
   logic        in_ready, cpu_rst, load_done, load_err;
   logic [15:0] load_count;

   logic [31:0] s_rom_data;
   logic        s_in_ready, s_cpu_rst, s_load_done, s_load_err;
   logic [15:0] s_load_count;

   int n_assert = 0;
   int n_fail   = 0;

   inst_rom_loader #(.ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready), .load_start_i(load_start),
      .cpu_rst_o(cpu_rst), .load_done_o(load_done), .load_err_o(load_err), .load_count_o(load_count)
   );

   inst_rom_loader #(.ADDR_WIDTH(2)) dut_s (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(s_rom_data),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(s_in_ready), .load_start_i(load_start),
      .cpu_rst_o(s_cpu_rst), .load_done_o(s_load_done), .load_err_o(s_load_err),
      .load_count_o(s_load_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(posedge clk);
      #1;
      load_start = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      rom_ce   = 1'b1;
      rom_addr = a;
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      rom_ce     = 1'b0;
      rom_addr   = 32'd0;
      in_valid   = 1'b0;
      in_data    = 8'd0;
      load_start = 1'b0;

      // 1: reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_cpu_rst",  32'(cpu_rst), 32'd1);
      chk("rst_ready",    32'(in_ready), 32'd1);
      chk("rst_done",     32'(load_done), 32'd0);
      chk("rst_err",      32'(load_err), 32'd0);
      chk("rst_count",    32'(load_count), 32'd0);

      // 2: back-to-back image
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
      chk("t2_cpu_rst_mid", 32'(cpu_rst), 32'd1);
      send_byte(8'h93); send_byte(8'h05); send_byte(8'h20);
      chk("t2_done_before_last", 32'(load_done), 32'd0);
      send_byte(8'h00);
      chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("t2_done",    32'(load_done), 32'd1);
      chk("t2_ready",   32'(in_ready), 32'd0);
      chk("t2_count",   32'(load_count), 32'd2);
      rd(32'd4);
      chk("t2_mem1", rom_data, 32'h0020_0593);
      rd(32'd0);
      chk("t2_mem0", rom_data, 32'h0010_0513);
      rd(32'd7);
      chk("t2_addr_lsb_ignored", rom_data, 32'h0020_0593);

      // 3: same image with valid gaps
      pulse_start();
      chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t3_done",    32'(load_done), 32'd0);
      send_byte(8'h02); idle(2); send_byte(8'h00);
      chk("t3_count0", 32'(load_count), 32'd0);
      send_byte(8'h13); idle(1); send_byte(8'h05); send_byte(8'h10); idle(3);
      chk("t3_count0_mid", 32'(load_count), 32'd0);
      send_byte(8'h00);
      chk("t3_count1", 32'(load_count), 32'd1);
      idle(2);
      send_byte(8'h93); send_byte(8'h05); idle(1); send_byte(8'h20); idle(2); send_byte(8'h00);
      chk("t3_count2", 32'(load_count), 32'd2);
      chk("t3_done_end", 32'(load_done), 32'd1);
      rd(32'd0);
      chk("t3_mem0", rom_data, 32'h0010_0513);
      rd(32'd4);
      chk("t3_mem1", rom_data, 32'h0020_0593);
      rom_ce = 1'b0;
      #1;
      chk("t3_ce_low", rom_data, 32'd0);
      rd(32'h0001_0000);
      chk("t3_out_of_range", rom_data, 32'd0);

      // 4: empty image
      pulse_start();
      send_byte(8'h00);
      chk("t4_not_done_yet", 32'(load_done), 32'd0);
      send_byte(8'h00);
      chk("t4_done",    32'(load_done), 32'd1);
      chk("t4_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("t4_count",   32'(load_count), 32'd0);
      chk("t4_err",     32'(load_err), 32'd0);
      rd(32'd0);
      chk("t4_mem0", rom_data, 32'h0010_0513);
      rd(32'd4);
      chk("t4_mem1", rom_data, 32'h0020_0593);

      // 5: overflow on the 4-word instance
      pulse_start();
      send_byte(8'h05); send_byte(8'h00);
      for (int w = 0; w < 5; w++) begin
         for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(w));
      end
      chk("t5_s_err",     32'(s_load_err), 32'd1);
      chk("t5_s_count",   32'(s_load_count), 32'd5);
      chk("t5_s_done",    32'(s_load_done), 32'd1);
      chk("t5_s_cpu_rst", 32'(s_cpu_rst), 32'd0);
      chk("t5_s_ready",   32'(s_in_ready), 32'd0);
      chk("t5_err",       32'(load_err), 32'd0);
      chk("t5_count",     32'(load_count), 32'd5);
      rd(32'd0);
      chk("t5_s_mem0", s_rom_data, 32'hA0A0_A0A0);
      rd(32'd12);
      chk("t5_s_mem3", s_rom_data, 32'hA3A3_A3A3);
      rd(32'd16);
      chk("t5_s_addr16", s_rom_data, 32'd0);
      chk("t5_mem4", rom_data, 32'hA4A4_A4A4);

      // 6: reset mid-load, then full reload
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("t6_partial_count", 32'(load_count), 32'd1);
      chk("t6_partial_cpu_rst", 32'(cpu_rst), 32'd1);
      rd(32'd0);
      chk("t6_partial_mem0", rom_data, 32'h4433_2211);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t6_rst_count",   32'(load_count), 32'd0);
      chk("t6_rst_ready",   32'(in_ready), 32'd1);
      chk("t6_rst_mem0",    rom_data, 32'h4433_2211);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      in_valid = 1'b1;
      in_data  = 8'h04;
      #2;
      chk("t6_read_old_during_write", rom_data, 32'h4433_2211);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t6_new_mem0", rom_data, 32'h0403_0201);
      chk("t6_cpu_rst_mid", 32'(cpu_rst), 32'd1);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      rd(32'd4);
      chk("t6_new_mem1", rom_data, 32'h0807_0605);
      chk("t6_done",     32'(load_done), 32'd1);
      chk("t6_cpu_rst",  32'(cpu_rst), 32'd0);
      send_byte(8'hFF);
      chk("t6_ignored_in_done", 32'(load_count), 32'd2);
      pulse_start();
      chk("t6_start_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t6_start_ready",   32'(in_ready), 32'd1);
      chk("t6_start_count",   32'(load_count), 32'd0);
      chk("t6_start_done",    32'(load_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
